// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM state encodings and shared types for the sequential ALU
package alu_seq_pkg;
    typedef logic [4:0] op_t;
    localparam op_t OP_AND   = 5'b00000;
    localparam op_t OP_ADD   = 5'b00001;
    localparam op_t OP_OR    = 5'b01000;
    localparam op_t OP_NOR   = 5'b10000;
    localparam op_t OP_XOR   = 5'b11000;
    localparam op_t OP_SUB   = 5'b01001;
    localparam op_t OP_SLT   = 5'b01010;
    localparam op_t OP_SLTU  = 5'b01011;
    localparam op_t OP_SRL   = 5'b00100;
    localparam op_t OP_SRA   = 5'b01100;
    localparam op_t OP_SLL   = 5'b10100;
    localparam op_t OP_LUI   = 5'b11100;
    localparam op_t OP_MFHI  = 5'b01110;
    localparam op_t OP_MFLO  = 5'b01111;
    localparam op_t OP_MTHI  = 5'b10110;
    localparam op_t OP_MTLO  = 5'b10111;
    localparam op_t OP_MULT  = 5'b00010;
    localparam op_t OP_MULTU = 5'b00011;
    localparam op_t OP_DIV   = 5'b00110;
    localparam op_t OP_DIVU  = 5'b00111;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle between the EX stage and the ALU
interface alu_seq_if #(parameter int WIDTH = 32);
    import alu_seq_pkg::*;
    logic             in_valid;
    logic             in_ready;
    op_t              alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_srcA;
    logic             out_valid;
    logic [WIDTH-1:0] alu_res;
    logic             alu_int_ov;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output in_valid, alu_op, alu_a, alu_b, alu_srcA,
                    input in_ready, out_valid, alu_res, alu_int_ov, busy, hi, lo);
    modport slave (input in_valid, alu_op, alu_a, alu_b, alu_srcA,
                   output in_ready, out_valid, alu_res, alu_int_ov, busy, hi, lo);
endinterface

// File: rtl/alu_seq_muldiv_iter.sv
// alu_seq_muldiv_iter: shared shift-add multiplier / restoring divider on magnitudes with sign fix-up
module alu_seq_muldiv_iter #(parameter int WIDTH = 32) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             run,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res
);
    localparam int CW = $clog2(WIDTH);
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, prod;
    logic [WIDTH-1:0]   opb_q, opb_d, a_raw_q, a_raw_d, a_mag, b_mag, quo, rem;
    logic               div_q, div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, dz_q, dz_d;
    logic [WIDTH:0]     msum, rsh, diff;

    // load magnitudes and sign flags on start, then one shift-add or restore step per running cycle
    always_comb begin
        a_mag    = (op_signed & a[WIDTH-1]) ? -a : a;
        b_mag    = (op_signed & b[WIDTH-1]) ? -b : b;
        msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? opb_q : {WIDTH{1'b0}}};
        rsh      = acc_q[2*WIDTH-1:WIDTH-1];
        diff     = rsh - {1'b0, opb_q};
        cnt_d    = start ? CW'(WIDTH-1) : run ? cnt_q - CW'(1) : cnt_q;
        acc_d    = start ? {{WIDTH{1'b0}}, a_mag} : !run ? acc_q :
                   div_q ? {diff[WIDTH] ? rsh[WIDTH-1:0] : diff[WIDTH-1:0], acc_q[WIDTH-2:0], ~diff[WIDTH]} :
                   {msum, acc_q[WIDTH-1:1]};
        opb_d    = start ? b_mag : opb_q;
        a_raw_d  = start ? a : a_raw_q;
        div_d    = start ? op_div : div_q;
        neg_lo_d = start ? op_signed & (a[WIDTH-1] ^ b[WIDTH-1]) : neg_lo_q;
        neg_hi_d = start ? op_signed & (op_div ? a[WIDTH-1] : a[WIDTH-1] ^ b[WIDTH-1]) : neg_hi_q;
        dz_d     = start ? op_div & (b == '0) : dz_q;
    end

    // iteration state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            a_raw_q  <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            a_raw_q  <= a_raw_d;
            div_q    <= div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
        end
    end

    // sign correction of the magnitude result; divide by zero returns all-ones quotient and the dividend
    always_comb begin
        last   = cnt_q == '0;
        prod   = neg_lo_q ? -acc_q : acc_q;
        quo    = acc_q[WIDTH-1:0];
        rem    = acc_q[2*WIDTH-1:WIDTH];
        hi_res = dz_q ? a_raw_q : div_q ? (neg_hi_q ? -rem : rem) : prod[2*WIDTH-1:WIDTH];
        lo_res = dz_q ? {WIDTH{1'b1}} : div_q ? (neg_lo_q ? -quo : quo) : prod[WIDTH-1:0];
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered EX-stage ALU with iterative MULT/DIV into HI/LO and a valid/ready handshake
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SHAMT_LSB = 6
) (
    input logic       clk,
    input logic       reset,
    alu_seq_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d, lo_q, lo_d;
    logic             ov_q, ov_d, vld_q, vld_d;
    logic [WIDTH-1:0] a, b, sum, dif, sc_res, md_hi, md_lo;
    logic [SW-1:0]    shamt;
    logic             accept, is_mul, is_div, sc_ov, md_last;

    // decode and single-cycle datapath
    always_comb begin
        a      = bus.alu_a;
        b      = bus.alu_b;
        accept = bus.in_valid & (state_q == ST_IDLE);
        is_mul = (bus.alu_op == OP_MULT) | (bus.alu_op == OP_MULTU);
        is_div = (bus.alu_op == OP_DIV) | (bus.alu_op == OP_DIVU);
        shamt  = bus.alu_srcA ? a[SHAMT_LSB +: SW] : a[SW-1:0];
        sum    = a + b;
        dif    = a - b;
        sc_res = '0;
        sc_ov  = 1'b0;
        case (bus.alu_op)
            OP_AND:  sc_res = a & b;
            OP_ADD:  begin
                sc_res = sum;
                sc_ov  = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR:   sc_res = a | b;
            OP_NOR:  sc_res = ~(a | b);
            OP_XOR:  sc_res = a ^ b;
            OP_SUB:  begin
                sc_res = dif;
                sc_ov  = (a[WIDTH-1] != b[WIDTH-1]) & (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_SRL:  sc_res = b >> shamt;
            OP_SRA:  sc_res = $unsigned($signed(b) >>> shamt);
            OP_SLL:  sc_res = b << shamt;
            OP_LUI:  sc_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_MFHI: sc_res = hi_q;
            OP_MFLO: sc_res = lo_q;
            default: ;
        endcase
    end

    // FSM: single-cycle ops retire from IDLE; MULT/DIV iterate then commit HI/LO on FIX->IDLE
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        ov_d    = ov_q;
        vld_d   = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                if (is_mul | is_div) state_d = is_div ? ST_DIV : ST_MUL;
                else begin
                    res_d = sc_res;
                    ov_d  = sc_ov;
                    vld_d = 1'b1;
                    hi_d  = (bus.alu_op == OP_MTHI) ? a : hi_q;
                    lo_d  = (bus.alu_op == OP_MTLO) ? a : lo_q;
                end
            end
            ST_MUL, ST_DIV: state_d = md_last ? ST_FIX : state_q;
            default: begin
                state_d = ST_IDLE;
                hi_d    = md_hi;
                lo_d    = md_lo;
                res_d   = md_lo;
                ov_d    = 1'b0;
                vld_d   = 1'b1;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            ov_q    <= 1'b0;
            vld_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            ov_q    <= ov_d;
            vld_q   <= vld_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    alu_seq_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk       (clk),
        .reset     (reset),
        .start     (accept & (is_mul | is_div)),
        .run       ((state_q == ST_MUL) | (state_q == ST_DIV)),
        .op_div    (is_div),
        .op_signed ((bus.alu_op == OP_MULT) | (bus.alu_op == OP_DIV)),
        .a         (a),
        .b         (b),
        .last      (md_last),
        .hi_res    (md_hi),
        .lo_res    (md_lo)
    );

    assign bus.in_ready   = state_q == ST_IDLE;
    assign bus.busy       = state_q != ST_IDLE;
    assign bus.out_valid  = vld_q;
    assign bus.alu_res    = res_q;
    assign bus.alu_int_ov = ov_q;
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
endmodule
